fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, width of one FIFO word.
REQ-003 Parameter MAX_BURST, default 8, maximum words per grant (power of two, 2..64).
REQ-004 wclk  input  1  write-domain clock; all logic on rising edge.
REQ-005 wrst_n  input  1  synchronous active-low reset.
REQ-006 req_valid  input  NREQ  per-requester word valid.
REQ-007 req_data  input  NREQ*DATA_WIDTH  per-requester word; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  NREQ  per-requester end-of-packet marker, qualified by req_valid.
REQ-009 req_ready  output  NREQ  per-requester word accepted this cycle.
REQ-010 full  input  1  FIFO write-side full flag.
REQ-011 w_en  output  1  FIFO write enable.
REQ-012 wdata  output  DATA_WIDTH  FIFO write data.
REQ-013 grant_id  output  clog2(NREQ)  index of current/last granted requester.
REQ-014 busy  output  1  high while a grant is held.

Function
REQ-015 Two-state FSM: IDLE, BURST.
REQ-016 IDLE: if any req_valid high, register winner into grant_id, clear burst counter, go to BURST next edge; else stay IDLE.
REQ-017 Winner = round-robin: first requester with req_valid high, searching from (rr_ptr+1) mod NREQ upward with wrap.
REQ-018 Arbitration costs exactly one IDLE cycle; no word transfers in IDLE.
REQ-019 BURST: xfer = req_valid[grant_id] & ~full; w_en = xfer, req_ready[grant_id] = xfer, combinational, same cycle.
REQ-020 req_ready of non-granted requesters is 0; wdata = req_data[grant_id] whenever in BURST, 0 in IDLE.
REQ-021 Burst counter increments by 1 on each xfer only; stall cycles (valid low or full high) not counted.
REQ-022 Release: on xfer with req_last[grant_id]=1, or on the xfer that makes the count equal MAX_BURST -> IDLE next edge, rr_ptr <= grant_id.
REQ-023 Last and MAX_BURST on the same xfer -> single release, identical to REQ-022.
REQ-024 Granted requester deasserting req_valid mid-burst: grant held, no timeout.
REQ-025 full high: w_en and all req_ready low; resumes the cycle full falls, no word lost or duplicated.
REQ-026 busy = (state == BURST); grant_id holds its value through IDLE.
REQ-027 Counter width clog2(MAX_BURST)+1; never wraps within a grant.

Reset
REQ-028 wrst_n low at a rising edge: state IDLE, grant_id 0, counter 0, rr_ptr NREQ-1 (requester 0 highest priority first).
REQ-029 While wrst_n low: w_en, req_ready, busy forced 0, combinationally, including a cycle mid-burst.
REQ-030 Reset mid-burst abandons the burst; first grant after reset follows REQ-028 priority.

Structure
REQ-031 Package fifo_wr_arb_pkg holds the FSM state enumeration and the clog2 width helper.
REQ-032 Sub-module rr_arbiter: combinational NREQ-wide round-robin picker (inputs req, rr_ptr; outputs found, idx), instantiated once.

Verification
REQ-033 Reset, then req_valid=4'b0001, 3 words A0,A1,A2 with last on A2, full=0 -> IDLE 1 cycle, w_en high 3 consecutive cycles, wdata A0,A1,A2, then IDLE.
REQ-034 All four valid, 1-word packets each with last -> grants in order 0,1,2,3,0; each grant 1 IDLE + 1 BURST cycle.
REQ-035 Requester 2 streams 20 words, no last, MAX_BURST=8 -> released after word 8, requester 3 (valid) granted next; requester 2 regains after others.
REQ-036 full high for 3 cycles during word 2 of a 5-word burst -> w_en/req_ready low those cycles, 5 words written in order, counter unaffected.
REQ-037 wrst_n low 1 cycle after word 3 of a burst from requester 1 -> w_en=0 that cycle, busy=0 next, next grant goes to lowest-index valid requester.
REQ-038 Last asserted on the 8th word with MAX_BURST=8 -> exactly one release, rr_ptr = grant_id, no extra IDLE cycle.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arb_pkg
// Description : Shared FSM state encoding and width helper for the FIFO write
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_wr_arb_pkg;

    typedef logic [0:0] state_t;

    localparam state_t c_ST_IDLE  = 1'b0;
    localparam state_t c_ST_BURST = 1'b1;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; searches upward from
//               rr_ptr+1 with wrap and returns the first requesting index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int w_dist;
    int w_best;

    // Distance from rr_ptr+1 decides priority; the smallest distance wins.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_best = NREQ;
        w_dist = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - 1 - int'(rr_ptr)) % NREQ;
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                idx    = IDX_W'(i);
                found  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter merging NREQ word streams into a
//               single FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8
) (
    input  logic                                wclk,
    input  logic                                wrst_n,
    input  logic [NREQ-1:0]                     req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0]          req_data,
    input  logic [NREQ-1:0]                     req_last,
    output logic [NREQ-1:0]                     req_ready,
    input  logic                                full,
    output logic                                w_en,
    output logic [DATA_WIDTH-1:0]               wdata,
    output logic [clog2_min1(NREQ)-1:0]         grant_id,
    output logic                                busy
);

    localparam int c_IDX_W = clog2_min1(NREQ);
    localparam int c_CNT_W = clog2_min1(MAX_BURST) + 1;
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_BURST);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_grant_id;
    logic [c_IDX_W-1:0]   w_grant_nxt;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   w_rr_ptr_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_win_idx;
    logic                 w_in_burst;
    logic                 w_xfer;
    logic                 w_release;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (c_IDX_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .idx    (w_win_idx)
    );

    // Reset gates the handshake combinationally so nothing is written mid-reset.
    assign w_in_burst = (r_state == c_ST_BURST);
    assign w_xfer     = wrst_n & w_in_burst & req_valid[r_grant_id] & ~full;
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_release  = w_xfer & (req_last[r_grant_id] | (w_cnt_inc == c_MAX_CNT));

    assign w_en     = w_xfer;
    assign busy     = wrst_n & w_in_burst;
    assign grant_id = r_grant_id;
    assign wdata    = w_in_burst ? req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH]
                                 : '0;

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_state    <= c_ST_IDLE;
            r_grant_id <= '0;
            r_cnt      <= '0;
            r_rr_ptr   <= c_IDX_W'(NREQ - 1);
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant_id;
        w_cnt_nxt    = r_cnt;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_ST_BURST;
                    w_grant_nxt = w_win_idx;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_BURST: begin
                if (w_xfer) begin
                    w_cnt_nxt = w_cnt_inc;
                end
                // Last word and burst limit on the same transfer is one release.
                if (w_release) begin
                    w_state_nxt  = c_ST_IDLE;
                    w_rr_ptr_nxt = r_grant_id;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        wclk;
    logic        wrst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        full;
    logic        w_en;
    logic [7:0]  wdata;
    logic [1:0]  grant_id;
    logic        busy;

    logic [7:0]  d [4];
    logic [15:0] obs;
    logic [15:0] exp_v;
    int          checks;
    int          errors;

    assign req_data = {d[3], d[2], d[1], d[0]};
    assign obs      = {busy, w_en, req_ready, grant_id, wdata};

    fifo_wr_arbiter #(
        .NREQ       (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (8)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .full      (full),
        .w_en      (w_en),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [15:0] ex(input logic b, input logic w, input logic [3:0] r,
                                       input logic [1:0] id, input logic [7:0] data);
        return {b, w, r, id, data};
    endfunction

    task automatic cyc;
        @(posedge wclk);
        #1;
    endtask

    task automatic pulse_reset;
        wrst_n = 1'b0; req_valid = '0; req_last = '0; full = 1'b0;
        cyc;
        wrst_n = 1'b1;
    endtask

    task automatic test_reset;
        wrst_n = 1'b0; req_valid = 4'hF; req_last = '0; full = 1'b0;
        cyc; cyc;
        #1; checks++; exp_v = ex(0, 0, 4'h0, 2'd0, 8'h00);
        if (obs !== exp_v) begin errors++; $display("FAIL reset_state obs=%h exp=%h", obs, exp_v); end
        wrst_n = 1'b1; req_valid = '0;
        cyc;
        #1; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_idle obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_single;
        req_valid = 4'b0001; d[0] = 8'hA0;
        #1; checks++; exp_v = ex(0, 0, 4'h0, 2'd0, 8'h00);
        if (obs !== exp_v) begin errors++; $display("FAIL single_idle obs=%h exp=%h", obs, exp_v); end
        cyc;
        for (int n = 0; n < 3; n++) begin
            d[0] = 8'(8'hA0 + n); req_last[0] = (n == 2);
            #1; checks++; exp_v = ex(1, 1, 4'b0001, 2'd0, 8'(8'hA0 + n));
            if (obs !== exp_v) begin errors++; $display("FAIL single_w%0d obs=%h exp=%h", n, obs, exp_v); end
            cyc;
        end
        req_valid = '0; req_last = '0;
        #1; checks++; exp_v = ex(0, 0, 4'h0, 2'd0, 8'h00);
        if (obs !== exp_v) begin errors++; $display("FAIL single_release obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_round_robin;
        pulse_reset;
        req_valid = 4'hF; req_last = 4'hF;
        for (int i = 0; i < 4; i++) d[i] = 8'(8'h10 + i);
        for (int k = 0; k < 5; k++) begin
            #1; checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle%0d busy=%b exp=0", k, busy); end
            cyc;
            #1; checks++; exp_v = ex(1, 1, 4'(1 << (k % 4)), 2'(k % 4), 8'(8'h10 + (k % 4)));
            if (obs !== exp_v) begin errors++; $display("FAIL rr_grant%0d obs=%h exp=%h", k, obs, exp_v); end
            cyc;
        end
        req_valid = '0; req_last = '0;
    endtask

    task automatic test_max_burst;
        pulse_reset;
        req_valid = 4'b1100; req_last = 4'b1000; d[3] = 8'h30; d[2] = 8'h20;
        #1; checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mb_idle busy=%b exp=0", busy); end
        cyc;
        for (int n = 0; n < 8; n++) begin
            d[2] = 8'(8'h20 + n);
            #1; checks++; exp_v = ex(1, 1, 4'b0100, 2'd2, 8'(8'h20 + n));
            if (obs !== exp_v) begin errors++; $display("FAIL mb_w%0d obs=%h exp=%h", n, obs, exp_v); end
            cyc;
        end
        #1; checks++; exp_v = ex(0, 0, 4'h0, 2'd2, 8'h00);
        if (obs !== exp_v) begin errors++; $display("FAIL mb_release obs=%h exp=%h", obs, exp_v); end
        cyc;
        #1; checks++; exp_v = ex(1, 1, 4'b1000, 2'd3, 8'h30);
        if (obs !== exp_v) begin errors++; $display("FAIL mb_next3 obs=%h exp=%h", obs, exp_v); end
        cyc;
        #1; checks++; exp_v = ex(0, 0, 4'h0, 2'd3, 8'h00);
        if (obs !== exp_v) begin errors++; $display("FAIL mb_idle3 obs=%h exp=%h", obs, exp_v); end
        cyc;
        // Requester 2 regains the grant; last coincides with the 8th word.
        for (int n = 0; n < 8; n++) begin
            d[2] = 8'(8'h40 + n); req_last[2] = (n == 7);
            #1; checks++; exp_v = ex(1, 1, 4'b0100, 2'd2, 8'(8'h40 + n));
            if (obs !== exp_v) begin errors++; $display("FAIL lm_w%0d obs=%h exp=%h", n, obs, exp_v); end
            cyc;
        end
        #1; checks++; exp_v = ex(0, 0, 4'h0, 2'd2, 8'h00);
        if (obs !== exp_v) begin errors++; $display("FAIL lm_release obs=%h exp=%h", obs, exp_v); end
        cyc;
        #1; checks++; exp_v = ex(1, 1, 4'b1000, 2'd3, 8'h30);
        if (obs !== exp_v) begin errors++; $display("FAIL lm_next3 obs=%h exp=%h", obs, exp_v); end
        cyc;
        req_valid = '0; req_last = '0;
        #1; checks++; exp_v = ex(0, 0, 4'h0, 2'd3, 8'h00);
        if (obs !== exp_v) begin errors++; $display("FAIL lm_done obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_full_stall;
        req_valid = 4'b0010; req_last = '0; full = 1'b0; d[1] = 8'hB0;
        #1; checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL fs_idle busy=%b exp=0", busy); end
        cyc;
        for (int n = 0; n < 5; n++) begin
            if (n == 2) begin
                full = 1'b1; d[1] = 8'hB2;
                for (int s = 0; s < 3; s++) begin
                    #1; checks++; exp_v = ex(1, 0, 4'h0, 2'd1, 8'hB2);
                    if (obs !== exp_v) begin errors++; $display("FAIL fs_stall%0d obs=%h exp=%h", s, obs, exp_v); end
                    cyc;
                end
                full = 1'b0;
            end
            d[1] = 8'(8'hB0 + n); req_last[1] = (n == 4);
            #1; checks++; exp_v = ex(1, 1, 4'b0010, 2'd1, 8'(8'hB0 + n));
            if (obs !== exp_v) begin errors++; $display("FAIL fs_w%0d obs=%h exp=%h", n, obs, exp_v); end
            cyc;
        end
        req_valid = '0; req_last = '0;
        #1; checks++; exp_v = ex(0, 0, 4'h0, 2'd1, 8'h00);
        if (obs !== exp_v) begin errors++; $display("FAIL fs_release obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_stall_count;
        req_valid = 4'b0001; d[0] = 8'hC0;
        #1; checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL sc_idle busy=%b exp=0", busy); end
        cyc;
        for (int n = 0; n < 8; n++) begin
            if (n == 1) begin
                full = 1'b1; d[0] = 8'hC1;
                for (int s = 0; s < 3; s++) begin
                    #1; checks++; exp_v = ex(1, 0, 4'h0, 2'd0, 8'hC1);
                    if (obs !== exp_v) begin errors++; $display("FAIL sc_full%0d obs=%h exp=%h", s, obs, exp_v); end
                    cyc;
                end
                full = 1'b0;
            end
            if (n == 4) begin
                req_valid = '0; d[0] = 8'hC4;
                for (int s = 0; s < 2; s++) begin
                    #1; checks++; exp_v = ex(1, 0, 4'h0, 2'd0, 8'hC4);
                    if (obs !== exp_v) begin errors++; $display("FAIL sc_gap%0d obs=%h exp=%h", s, obs, exp_v); end
                    cyc;
                end
                req_valid = 4'b0001;
            end
            d[0] = 8'(8'hC0 + n);
            #1; checks++; exp_v = ex(1, 1, 4'b0001, 2'd0, 8'(8'hC0 + n));
            if (obs !== exp_v) begin errors++; $display("FAIL sc_w%0d obs=%h exp=%h", n, obs, exp_v); end
            cyc;
        end
        req_valid = '0;
        #1; checks++; exp_v = ex(0, 0, 4'h0, 2'd0, 8'h00);
        if (obs !== exp_v) begin errors++; $display("FAIL sc_release obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_reset_mid_burst;
        req_valid = 4'b0010; req_last = '0; d[1] = 8'hD0;
        #1; checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle busy=%b exp=0", busy); end
        cyc;
        for (int n = 0; n < 3; n++) begin
            d[1] = 8'(8'hD0 + n);
            #1; checks++; exp_v = ex(1, 1, 4'b0010, 2'd1, 8'(8'hD0 + n));
            if (obs !== exp_v) begin errors++; $display("FAIL rm_w%0d obs=%h exp=%h", n, obs, exp_v); end
            cyc;
        end
        wrst_n = 1'b0; req_valid = 4'b1011; d[0] = 8'hE0;
        #1; checks++;
        if ({busy, w_en, req_ready} !== 6'b0) begin
            errors++; $display("FAIL rm_forced obs=%b exp=000000", {busy, w_en, req_ready});
        end
        cyc;
        wrst_n = 1'b1;
        #1; checks++; exp_v = ex(0, 0, 4'h0, 2'd0, 8'h00);
        if (obs !== exp_v) begin errors++; $display("FAIL rm_after obs=%h exp=%h", obs, exp_v); end
        cyc;
        req_last[0] = 1'b1;
        #1; checks++; exp_v = ex(1, 1, 4'b0001, 2'd0, 8'hE0);
        if (obs !== exp_v) begin errors++; $display("FAIL rm_regrant obs=%h exp=%h", obs, exp_v); end
        cyc;
        req_valid = '0; req_last = '0;
        #1; checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rm_done busy=%b exp=0", busy); end
    endtask

    initial begin
        checks = 0; errors = 0;
        wrst_n = 1'b0; req_valid = '0; req_last = '0; full = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_max_burst;
        test_full_stall;
        test_stall_count;
        test_reset_mid_burst;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
